// File: rtl/ap_ctrl_pkg.sv
// Shared types and helpers for the ap_ctrl_hs / ap_ctrl_chain handshake driver.
//   ap_drv_state_e : driver run state (IDLE -> RUN -> FINISH, FINISH restartable)
//   Def*           : default widths and outstanding-transaction limit
//   lat_calc       : start-to-done latency, modulo 2^32; callers truncate to their
//                    own timestamp width (<= 32 bits)
package ap_ctrl_pkg;

  localparam int unsigned DefCntW   = 16;
  localparam int unsigned DefTsW    = 24;
  localparam int unsigned DefMaxOut = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } ap_drv_state_e;

  // Unsigned subtraction wraps, so the low TS_W bits of the result are the
  // latency modulo 2^TS_W even after the timestamp counter has rolled over.
  function automatic logic [31:0] lat_calc(input logic [31:0] now_ts,
                                           input logic [31:0] head_ts);
    return now_ts - head_ts;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous FIFO holding issue timestamps of outstanding transactions.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empty the FIFO (start of a new run)
//   push_i/data_i : write a timestamp; ignored when full unless popping too
//   pop_i/data_o  : data_o is the head entry; pop ignored when empty
//   full_o/empty_o: occupancy flags
module ts_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so push-while-full is legal then.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs / ap_ctrl_chain block-level handshake.
// Issues cfg_num_txn transactions through ap_start/ap_ready, acknowledges
// completions through ap_done/ap_continue with a programmable gap, measures the
// start-to-done latency of every transaction and raises finish at the end.
//   clock, reset     : clock, asynchronous active-low reset
//   cfg_start        : pulse to begin a run (honoured in IDLE / FINISH)
//   cfg_num_txn      : transactions per run, sampled on cfg_start
//   cfg_cont_gap     : idle cycles before re-asserting ap_continue after a done
//   ap_start/ap_ready: issue handshake
//   ap_done/ap_continue: completion handshake
//   busy, finish     : run in progress / run complete
//   issued_cnt, done_cnt : saturating handshake counters for the current run
//   last_lat, max_lat: latency of the most recent completion / run maximum
//   err_proto        : sticky protocol error, cleared by cfg_start
module ap_ctrl_hs_driver
  import ap_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned TS_W    = DefTsW,
  parameter int unsigned MAX_OUT = DefMaxOut
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_txn,
  input  logic [7:0]       cfg_cont_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [TS_W-1:0]  last_lat,
  output logic [TS_W-1:0]  max_lat,
  output logic             err_proto
);

  localparam logic [CNT_W:0] MaxOutW = (CNT_W + 1)'(MAX_OUT);

  ap_drv_state_e    state_q, state_d;
  logic [CNT_W-1:0] num_txn_q, num_txn_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] outstanding;
  logic [7:0]       cont_gap_q, cont_gap_d;
  logic [7:0]       gc_q, gc_d;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  last_lat_q, last_lat_d;
  logic [TS_W-1:0]  max_lat_q, max_lat_d;
  logic [TS_W-1:0]  lat;
  logic             err_q, err_d;
  logic             ap_start_q, ap_start_d;

  logic             cfg_accept;
  logic             issue_hs;
  logic             done_hs;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TS_W-1:0]  fifo_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cfg_accept = cfg_start && (state_q != RUN);
  assign issue_hs   = ap_start_q && ap_ready;
  assign done_hs    = ap_done && (gc_q == 8'd0);
  assign fifo_push  = issue_hs;
  assign fifo_pop   = (state_q == RUN) && done_hs && !fifo_empty;
  assign lat        = TS_W'(lat_calc(32'(ts_q), 32'(fifo_head)));

  ts_fifo #(
    .Depth(MAX_OUT),
    .Width(TS_W)
  ) u_ts_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .flush_i(cfg_accept),
    .push_i (fifo_push && !fifo_full),
    .data_i (ts_q),
    .pop_i  (fifo_pop),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    num_txn_d  = num_txn_q;
    cont_gap_d = cont_gap_q;
    issued_d   = issued_q;
    done_d     = done_q;
    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    err_d      = err_q;
    gc_d       = (gc_q != 8'd0) ? gc_q - 8'd1 : gc_q;

    if (ap_ready && !ap_start_q)        err_d = 1'b1;
    if (ap_done && (state_q == IDLE))   err_d = 1'b1;

    unique case (state_q)
      IDLE, FINISH: begin
        if (cfg_start) begin
          num_txn_d  = cfg_num_txn;
          cont_gap_d = cfg_cont_gap;
          issued_d   = '0;
          done_d     = '0;
          last_lat_d = '0;
          max_lat_d  = '0;
          err_d      = 1'b0;
          gc_d       = 8'd0;
          state_d    = (cfg_num_txn == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (issue_hs) issued_d = sat_inc(issued_q);
        if (done_hs) begin
          done_d = sat_inc(done_q);
          gc_d   = cont_gap_q;
          if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            last_lat_d = lat;
            if (lat > max_lat_q) max_lat_d = lat;
          end
          if (done_d == num_txn_q) state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Computed from next-state counts so ap_start drops right after the
    // handshake that hits a limit and re-rises right after a freeing done.
    outstanding = issued_d - done_d;
    ap_start_d  = (state_d == RUN) && (issued_d < num_txn_d) &&
                  ({1'b0, outstanding} < MaxOutW);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      num_txn_q  <= '0;
      cont_gap_q <= '0;
      issued_q   <= '0;
      done_q     <= '0;
      gc_q       <= '0;
      ts_q       <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      err_q      <= 1'b0;
      ap_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_txn_q  <= num_txn_d;
      cont_gap_q <= cont_gap_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      gc_q       <= gc_d;
      ts_q       <= ts_q + TS_W'(1);
      last_lat_q <= last_lat_d;
      max_lat_q  <= max_lat_d;
      err_q      <= err_d;
      ap_start_q <= ap_start_d;
    end
  end

  assign ap_start    = ap_start_q;
  assign ap_continue = (gc_q == 8'd0);
  assign busy        = (state_q == RUN);
  assign finish      = (state_q == FINISH);
  assign issued_cnt  = issued_q;
  assign done_cnt    = done_q;
  assign last_lat    = last_lat_q;
  assign max_lat     = max_lat_q;
  assign err_proto   = err_q;

endmodule
